// File: rtl/mem_port_b_arbiter_if.sv
// Port-B sharing bus: two requester channels, their response channels and the
// BRAM port-B pins. The "slave" modport is the arbiter's view. The "master"
// modport is the environment: requesters plus the memory.
interface mem_port_b_arbiter_if #(
    parameter int AW = 13
);
    // Requester 0 (CPU load/store unit)
    logic          req0_valid;
    logic          req0_ready;
    logic [AW-1:0] req0_addr;
    logic [31:0]   req0_wdata;
    logic [3:0]    req0_be;
    logic          req0_we;
    logic          rsp0_valid;
    logic [31:0]   rsp0_rdata;

    // Requester 1 (debug/loader master)
    logic          req1_valid;
    logic          req1_ready;
    logic [AW-1:0] req1_addr;
    logic [31:0]   req1_wdata;
    logic [3:0]    req1_be;
    logic          req1_we;
    logic          rsp1_valid;
    logic [31:0]   rsp1_rdata;

    // Memory port B
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_data_i;
    logic [3:0]    mem_data_en;
    logic          mem_write_en;
    logic [31:0]   mem_data_o;

    modport slave (
        input  req0_valid, req0_addr, req0_wdata, req0_be, req0_we,
        output req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_valid, req1_addr, req1_wdata, req1_be, req1_we,
        output req1_ready, rsp1_valid, rsp1_rdata,
        output mem_addr, mem_data_i, mem_data_en, mem_write_en,
        input  mem_data_o
    );

    modport master (
        output req0_valid, req0_addr, req0_wdata, req0_be, req0_we,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        output req1_valid, req1_addr, req1_wdata, req1_be, req1_we,
        input  req1_ready, rsp1_valid, rsp1_rdata,
        input  mem_addr, mem_data_i, mem_data_en, mem_write_en,
        output mem_data_o
    );
endinterface

// File: rtl/mem_port_b_arbiter.sv
// Arbiter for the write-capable BRAM port B, shared by requester 0 (CPU LSU)
// and requester 1 (debug/loader). Grants are combinational and exclusive, and
// the response follows exactly one cycle after the grant.
// Build option MEM_ARB_ROUND_ROBIN_EN: if defined, a 1-bit round-robin pointer
// replaces the default fixed-priority-plus-starvation-counter scheme.
module mem_port_b_arbiter #(
    parameter int MEM_SIZE     = 8192,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_b_arbiter_if.slave  bus
);
    logic gnt0;
    logic gnt1;

    // Response tag: one access in flight per cycle, answered the next cycle.
    logic rsp_pend_q, rsp_pend_d;
    logic rsp_id_q,   rsp_id_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Identity of the requester that won the most recent grant.
    logic last_gnt_q, last_gnt_d;

    // Exclusive grant; on contention the requester that did not win last time
    // wins. Grants are suppressed while reset is held.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            gnt1 = bus.req1_valid && (!bus.req0_valid || !last_gnt_q);
            gnt0 = bus.req0_valid && !gnt1;
        end
    end

    // Remember the winner whenever any grant is issued.
    always_comb begin
        last_gnt_d = last_gnt_q;
        if (gnt0 || gnt1) begin
            last_gnt_d = gnt1;
        end
    end

    // Round-robin pointer starts at 1, so requester 0 wins the first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt_q <= 1'b1;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end
`else
    localparam int              CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0]   LIMIT = CW'(STARVE_LIMIT);

    // Consecutive cycles requester 1 has waited without being granted.
    logic [CW-1:0] starve_cnt_q, starve_cnt_d;

    // Exclusive grant; requester 0 has priority unless requester 1 has waited
    // STARVE_LIMIT cycles. Grants are suppressed while reset is held.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            gnt1 = bus.req1_valid && (!bus.req0_valid || starve_cnt_q == LIMIT);
            gnt0 = bus.req0_valid && !gnt1;
        end
    end

    // Count requester 1 waiting cycles, saturating at the limit.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!bus.req1_valid || gnt1) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != LIMIT) begin
            starve_cnt_d = starve_cnt_q + CW'(1);
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`endif

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;

    // Steer the granted requester onto the memory pins; idle drives all zeros
    // so the memory never sees a stray write.
    always_comb begin
        bus.mem_addr     = '0;
        bus.mem_data_i   = '0;
        bus.mem_data_en  = '0;
        bus.mem_write_en = 1'b0;
        if (gnt0) begin
            bus.mem_addr     = bus.req0_addr;
            bus.mem_data_i   = bus.req0_wdata;
            bus.mem_data_en  = bus.req0_be;
            bus.mem_write_en = bus.req0_we;
        end else if (gnt1) begin
            bus.mem_addr     = bus.req1_addr;
            bus.mem_data_i   = bus.req1_wdata;
            bus.mem_data_en  = bus.req1_be;
            bus.mem_write_en = bus.req1_we;
        end
    end

    // Next response tag comes straight from this cycle's grant.
    always_comb begin
        rsp_pend_d = gnt0 || gnt1;
        rsp_id_d   = gnt1;
    end

    // Response tag register; reset discards any access still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_pend_q <= 1'b0;
            rsp_id_q   <= 1'b0;
        end else begin
            rsp_pend_q <= rsp_pend_d;
            rsp_id_q   <= rsp_id_d;
        end
    end

    // The memory registers its read data, so it lines up with the tag.
    assign bus.rsp0_valid = rsp_pend_q && !rsp_id_q;
    assign bus.rsp1_valid = rsp_pend_q &&  rsp_id_q;
    assign bus.rsp0_rdata = bus.mem_data_o;
    assign bus.rsp1_rdata = bus.mem_data_o;

endmodule

// File: tb/tb_mem_port_b_arbiter.sv
// Bench for mem_port_b_arbiter: a BRAM model on port B, randomized requesters
// that hold requests until accepted, a reference model of the arbitration
// rules plus a shadow memory, and a scoreboard monitor for the responses.
`timescale 1ns/1ps
module tb_mem_port_b_arbiter;
    localparam int MEM_SIZE     = 8192;
    localparam int STARVE_LIMIT = 4;
    localparam int AW           = $clog2(MEM_SIZE);
    localparam int WORDS        = MEM_SIZE / 4;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [3:0]    be;
        logic          we;
    } req_t;

    typedef struct {
        bit          id;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic preload = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] bram    [WORDS];
    logic [31:0] ref_mem [WORDS];
    exp_t        sb[$];

    req_t r0, r1;
    bit   pend0, pend1;
    int   wait1;
    bit   last_win;

    always #5 clk = ~clk;

    mem_port_b_arbiter_if #(.AW(AW)) bus();

    mem_port_b_arbiter #(
        .MEM_SIZE     (MEM_SIZE),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'hDEADBEEF;
        if (i == 8) return 32'h0;
        return 32'(i);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] en);
        logic [31:0] w;
        w = old;
        for (int b = 0; b < 4; b++) if (en[b]) w[8*b +: 8] = d[8*b +: 8];
        return w;
    endfunction

    function automatic req_t mk(input int addr, input logic [31:0] wd,
                                input logic [3:0] be, input logic we);
        req_t r;
        r.addr = AW'(addr); r.wdata = wd; r.be = be; r.we = we;
        return r;
    endfunction

    function automatic req_t rand_req();
        return mk(int'($urandom_range(127)), $urandom, 4'($urandom),
                  1'($urandom_range(1)));
    endfunction

    // Read-first BRAM behind port B.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < WORDS; i++) bram[i] <= init_word(i);
        end else begin
            bus.mem_data_o <= bram[bus.mem_addr[AW-1:2]];
            if (bus.mem_write_en)
                bram[bus.mem_addr[AW-1:2]] <= merge(bram[bus.mem_addr[AW-1:2]],
                                                    bus.mem_data_i, bus.mem_data_en);
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic apply();
        bus.req0_valid = pend0; bus.req0_addr = r0.addr; bus.req0_wdata = r0.wdata;
        bus.req0_be    = r0.be; bus.req0_we   = r0.we;
        bus.req1_valid = pend1; bus.req1_addr = r1.addr; bus.req1_wdata = r1.wdata;
        bus.req1_be    = r1.be; bus.req1_we   = r1.we;
    endtask

    task automatic grant(input bit id, input req_t r);
        exp_t e;
        e.id   = id;
        e.data = ref_mem[r.addr[AW-1:2]];
        e.due  = cyc + 1;
        sb.push_back(e);
        if (r.we) ref_mem[r.addr[AW-1:2]] = merge(ref_mem[r.addr[AW-1:2]], r.wdata, r.be);
        chk("mem_drive", 64'({bus.mem_addr, bus.mem_data_i, bus.mem_data_en, bus.mem_write_en}),
            64'({r.addr, r.wdata, r.be, r.we}));
    endtask

    // Reference arbitration for one cycle, evaluated mid-cycle.
    task automatic model_step();
        bit g0, g1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        g1 = pend1 && (!pend0 || last_win == 1'b0);
`else
        g1 = pend1 && (!pend0 || wait1 >= STARVE_LIMIT);
`endif
        g0 = pend0 && !g1;
        chk("req0_ready", 64'(bus.req0_ready), 64'(g0));
        chk("req1_ready", 64'(bus.req1_ready), 64'(g1));
        if (g0) grant(1'b0, r0);
        if (g1) grant(1'b1, r1);
        if (!g0 && !g1)
            chk("idle_mem_drive", 64'({bus.mem_addr, bus.mem_data_en, bus.mem_write_en}), 64'(0));
        if (!pend1 || g1) wait1 = 0;
        else if (wait1 < STARVE_LIMIT) wait1++;
        if (g0 || g1) last_win = g1;
        if (g0) pend0 = 1'b0;
        if (g1) pend1 = 1'b0;
    endtask

    // One clock cycle: maybe launch new requests, then model and check.
    task automatic drive_cycle(input int p0, input int p1);
        if (!pend0 && int'($urandom_range(99)) < p0) begin r0 = rand_req(); pend0 = 1'b1; end
        if (!pend1 && int'($urandom_range(99)) < p1) begin r1 = rand_req(); pend1 = 1'b1; end
        apply();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every response is matched against the oldest expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            if (bus.rsp0_valid && bus.rsp1_valid) chk("rsp_exclusive", 64'(1), 64'(0));
            if (bus.rsp0_valid || bus.rsp1_valid) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 64'(1), 64'(0));
                end else begin
                    e = sb.pop_front();
                    chk("rsp_id", 64'(bus.rsp1_valid), 64'(e.id));
                    chk("rsp_cycle", 64'(cyc), 64'(e.due));
                    chk("rsp_rdata", 64'(e.id ? bus.rsp1_rdata : bus.rsp0_rdata), 64'(e.data));
                end
            end else if (sb.size() > 0 && sb[0].due < cyc) begin
                e = sb.pop_front();
                chk("rsp_missing", 64'(0), 64'(1));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
        pend0 = 1'b0; pend1 = 1'b0; wait1 = 0; last_win = 1'b1;
        r0 = mk(0, 0, 0, 0); r1 = mk(0, 0, 0, 0);
        apply();
        repeat (2) @(posedge clk);
        #1;
        // Requests during reset must not be granted.
        pend0 = 1'b1; pend1 = 1'b1; r0 = mk(8, 32'hA5A5A5A5, 4'hF, 1'b1); r1 = r0;
        apply();
        #1;
        chk("reset_ready0", 64'(bus.req0_ready), 64'(0));
        chk("reset_ready1", 64'(bus.req1_ready), 64'(0));
        chk("reset_write_en", 64'(bus.mem_write_en), 64'(0));
        chk("reset_rsp", 64'({bus.rsp0_valid, bus.rsp1_valid}), 64'(0));
        pend0 = 1'b0; pend1 = 1'b0;
        apply();
        @(posedge clk);
        preload = 1'b0;
        #1;
        rst = 1'b0;

        repeat (2) drive_cycle(0, 0);
        // Single read of the preloaded word.
        r0 = mk('h10, 0, 4'hF, 1'b0); pend0 = 1'b1;
        repeat (2) drive_cycle(0, 0);
        // Byte write from requester 1, then read it back.
        r1 = mk('h20, 32'h11223344, 4'b0010, 1'b1); pend1 = 1'b1;
        drive_cycle(0, 0);
        r1 = mk('h20, 0, 4'hF, 1'b0); pend1 = 1'b1;
        repeat (2) drive_cycle(0, 0);
        // Back-to-back reads of words 0, 1, 2.
        for (int i = 0; i < 3; i++) begin
            r0 = mk(4 * i, 0, 4'hF, 1'b0); pend0 = 1'b1;
            drive_cycle(0, 0);
        end
        drive_cycle(0, 0);
        // Continuous contention, then random traffic.
        repeat (12) drive_cycle(100, 100);
        repeat (400) drive_cycle(60, 60);
        repeat (2) drive_cycle(0, 0);

        // Reset asserted the cycle after a grant drops the pending response.
        r0 = mk('h10, 0, 4'hF, 1'b0); pend0 = 1'b1;
        drive_cycle(0, 0);
        pend0 = 1'b1; pend1 = 1'b1; r0 = mk('h30, 32'h12345678, 4'hF, 1'b1); r1 = r0;
        apply();
        rst = 1'b1;
        sb.delete();
        #1;
        chk("midrst_rsp0", 64'(bus.rsp0_valid), 64'(0));
        chk("midrst_rsp1", 64'(bus.rsp1_valid), 64'(0));
        chk("midrst_ready", 64'({bus.req0_ready, bus.req1_ready}), 64'(0));
        chk("midrst_write_en", 64'(bus.mem_write_en), 64'(0));
        pend0 = 1'b0; pend1 = 1'b0; wait1 = 0; last_win = 1'b1;
        apply();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (12) drive_cycle(100, 100);
        repeat (200) drive_cycle(50, 70);
        repeat (3) drive_cycle(0, 0);
        chk("sb_drained", 64'(sb.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
